// File: rtl/axi_bridge_pkg.sv
// Shared types and AXI encodings for the SRAM-to-AXI3 bridge.
package axi_bridge_pkg;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} wr_state_t;

    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] SIZE_BYTE      = 2'd0;
    localparam logic [1:0] SIZE_HALF      = 2'd1;
    localparam logic [1:0] SIZE_WORD      = 2'd2;
    localparam int         BRIDGE_WR_ID   = 1;

    function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
        return {1'b0, sram_size};
    endfunction

endpackage

// File: rtl/axi_bridge_rr_arbiter.sv
// Round-robin arbiter: first requester at or above the pointer wins, wrapping at N.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_valid
);
    localparam int SW = PW + 1;

    logic [N-1:0]  w_rot;
    logic [PW-1:0] w_pos;
    logic [SW-1:0] w_sum;

    // Rotate so the pointer position lands on bit 0, then pick the lowest set bit.
    assign w_rot = N'({i_req, i_req} >> i_ptr);

    always_comb begin
        w_pos = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) w_pos = PW'(j);
        end
    end

    assign w_sum   = SW'(w_pos) + SW'(i_ptr);
    assign o_idx   = (w_sum >= SW'(N)) ? PW'(w_sum - SW'(N)) : PW'(w_sum);
    assign o_valid = |i_req;
    assign o_grant = o_valid ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/axi_bridge.sv
// Bridges NUM_RPORTS SRAM-like read ports and one write port onto a single AXI3 master.
module axi_bridge
    import axi_bridge_pkg::*;
#(
    parameter int NUM_RPORTS = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ID_W       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_RPORTS-1:0]        rd_req,
    input  logic [NUM_RPORTS*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RPORTS*2-1:0]      rd_size,
    output logic [NUM_RPORTS-1:0]        rd_addr_ok,
    output logic [NUM_RPORTS-1:0]        rd_data_ok,
    output logic [DATA_W-1:0]            rd_rdata,
    input  logic                         wr_req,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [1:0]                   wr_size,
    input  logic [DATA_W/8-1:0]          wr_wstrb,
    input  logic [DATA_W-1:0]            wr_wdata,
    output logic                         wr_addr_ok,
    output logic                         wr_data_ok,
    output logic [ID_W-1:0]              arid,
    output logic [ADDR_W-1:0]            araddr,
    output logic [2:0]                   arsize,
    output logic                         arvalid,
    input  logic                         arready,
    input  logic [ID_W-1:0]              rid,
    input  logic [DATA_W-1:0]            rdata,
    input  logic [1:0]                   rresp,
    input  logic                         rlast,
    input  logic                         rvalid,
    output logic                         rready,
    output logic [ID_W-1:0]              awid,
    output logic [ADDR_W-1:0]            awaddr,
    output logic [2:0]                   awsize,
    output logic                         awvalid,
    input  logic                         awready,
    output logic [ID_W-1:0]              wid,
    output logic [DATA_W-1:0]            wdata,
    output logic [DATA_W/8-1:0]          wstrb,
    output logic                         wlast,
    output logic                         wvalid,
    input  logic                         wready,
    input  logic [ID_W-1:0]              bid,
    input  logic [1:0]                   bresp,
    input  logic                         bvalid,
    output logic                         bready,
    output logic [7:0]                   arlen,
    output logic [1:0]                   arburst,
    output logic [1:0]                   arlock,
    output logic [3:0]                   arcache,
    output logic [2:0]                   arprot,
    output logic [7:0]                   awlen,
    output logic [1:0]                   awburst,
    output logic [1:0]                   awlock,
    output logic [3:0]                   awcache,
    output logic [2:0]                   awprot
);
    localparam int PW = (NUM_RPORTS > 1) ? $clog2(NUM_RPORTS) : 1;

    rd_state_t             r_rstate, w_rstate_next;
    wr_state_t             r_wstate, w_wstate_next;
    logic [PW-1:0]         r_ptr;
    logic [ADDR_W-1:0]     r_araddr, r_awaddr;
    logic [2:0]            r_arsize;
    logic [ID_W-1:0]       r_arid;
    logic [1:0]            r_wsize;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_aw_done, r_w_done;

    logic [ADDR_W-1:0]     w_raddr [NUM_RPORTS];
    logic [1:0]            w_rsize [NUM_RPORTS];
    logic [NUM_RPORTS-1:0] w_cand, w_arb_req, w_grant;
    logic [PW-1:0]         w_gidx;
    logic                  w_gvalid, w_aw_fin, w_w_fin, w_unused;

    // A read that hits the word held by an in-flight store waits until that store is acknowledged.
    for (genvar gi = 0; gi < NUM_RPORTS; gi++) begin : g_port
        assign w_raddr[gi]    = rd_addr[gi*ADDR_W +: ADDR_W];
        assign w_rsize[gi]    = rd_size[gi*2 +: 2];
        assign w_cand[gi]     = rd_req[gi] &&
                                !((r_wstate != W_IDLE) && (w_raddr[gi][ADDR_W-1:2] == r_awaddr[ADDR_W-1:2]));
        assign rd_data_ok[gi] = (r_rstate == R_R) && rvalid && (r_arid == ID_W'(gi));
    end

    assign w_arb_req = ((r_rstate == R_IDLE) && !reset) ? w_cand : '0;

    rr_arbiter #(.N(NUM_RPORTS), .PW(PW)) u_rr_arbiter (
        .i_req   (w_arb_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_valid (w_gvalid)
    );

    assign w_aw_fin = r_aw_done || awready;
    assign w_w_fin  = r_w_done  || wready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate  <= R_IDLE;
            r_wstate  <= W_IDLE;
            r_ptr     <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_rstate <= w_rstate_next;
            r_wstate <= w_wstate_next;
            if (w_gvalid) begin
                r_araddr <= w_raddr[w_gidx];
                r_arsize <= axi_size(w_rsize[w_gidx]);
                r_arid   <= ID_W'(w_gidx);
                r_ptr    <= (w_gidx == PW'(NUM_RPORTS - 1)) ? '0 : w_gidx + PW'(1);
            end
            if (wr_addr_ok) begin
                r_awaddr  <= wr_addr;
                r_wsize   <= wr_size;
                r_wstrb   <= wr_wstrb;
                r_wdata   <= wr_wdata;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else if (r_wstate == W_REQ) begin
                if (awvalid && awready) r_aw_done <= 1'b1;
                if (wvalid && wready)   r_w_done  <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rstate_next = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_gvalid) w_rstate_next = R_AR;
            R_AR:    if (arready)  w_rstate_next = R_R;
            R_R:     if (rvalid)   w_rstate_next = R_IDLE;
            default: w_rstate_next = R_IDLE;
        endcase
        w_wstate_next = r_wstate;
        case (r_wstate)
            W_IDLE:  if (wr_req)              w_wstate_next = W_REQ;
            W_REQ:   if (w_aw_fin && w_w_fin) w_wstate_next = W_B;
            W_B:     if (bvalid)              w_wstate_next = W_IDLE;
            default: w_wstate_next = W_IDLE;
        endcase
    end

    always_comb begin
        rd_addr_ok = w_grant;
        arvalid    = (r_rstate == R_AR);
        rready     = (r_rstate == R_R);
        wr_addr_ok = (r_wstate == W_IDLE) && wr_req && !reset;
        awvalid    = (r_wstate == W_REQ) && !r_aw_done;
        wvalid     = (r_wstate == W_REQ) && !r_w_done;
        bready     = (r_wstate == W_B);
        wr_data_ok = (r_wstate == W_B) && bvalid;
    end

    assign rd_rdata = rdata;
    assign arid     = r_arid;
    assign araddr   = r_araddr;
    assign arsize   = r_arsize;
    assign awid     = ID_W'(BRIDGE_WR_ID);
    assign wid      = ID_W'(BRIDGE_WR_ID);
    assign awaddr   = r_awaddr;
    assign awsize   = axi_size(r_wsize);
    assign wdata    = r_wdata;
    assign wstrb    = r_wstrb;
    assign wlast    = 1'b1;

    assign arlen   = AXI_LEN_SINGLE;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign awlen   = AXI_LEN_SINGLE;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;

    // Single outstanding read/write, so response IDs, status and rlast carry no information.
    assign w_unused = &{1'b0, rid, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_axi_bridge.sv
// Scoreboard bench for axi_bridge with a latency-configurable AXI slave model.
module tb_axi_bridge;

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
    } rd_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strb;
        logic [31:0] data;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rd_req;
    logic [63:0] rd_addr;
    logic [3:0]  rd_size;
    logic [1:0]  rd_addr_ok, rd_data_ok;
    logic [31:0] rd_rdata;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [1:0]  wr_size;
    logic [3:0]  wr_wstrb;
    logic [31:0] wr_wdata;
    logic        wr_addr_ok, wr_data_ok;
    logic [3:0]  arid, rid, awid, wid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp, arburst, arlock, awburst, awlock;
    logic [3:0]  wstrb, arcache, awcache;
    logic [7:0]  arlen, awlen;

    axi_bridge #(.NUM_RPORTS(2), .ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size),
        .rd_addr_ok(rd_addr_ok), .rd_data_ok(rd_data_ok), .rd_rdata(rd_rdata),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size), .wr_wstrb(wr_wstrb), .wr_wdata(wr_wdata),
        .wr_addr_ok(wr_addr_ok), .wr_data_ok(wr_data_ok),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arlen(arlen), .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .awlen(awlen), .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot)
    );

    always #5 clk = ~clk;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    int n_vec = 0, n_err = 0, cyc = 0, wr_ok_cyc = -1, rd_ok_cnt = 0;
    int ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (a == 32'h1c00_0000) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Slave model and monitor: handshakes sampled mid-cycle, slave outputs updated just after the edge.
    initial begin : slave
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, b_pend, aw_got, w_got;
        int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
        logic [31:0] s_araddr, s_awaddr, s_wdata;
        logic [3:0]  s_arid, s_awid, s_wid, s_wstrb;
        logic [2:0]  s_awsize;
        logic        s_wlast;
        rd_exp_t re;
        wr_exp_t we;
        {ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, b_pend, aw_got, w_got} = '0;
        {ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt} = '0;
        {s_araddr, s_awaddr, s_wdata, s_arid, s_awid, s_wid, s_wstrb, s_awsize, s_wlast} = '0;
        arready = 0; rvalid = 0; rdata = 0; rid = 0; rresp = 0; rlast = 0;
        awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
        forever begin
            @(negedge clk);
            {ar_hs, r_hs, aw_hs, w_hs, b_hs} = '0;
            if (!reset) begin
                ar_hs = arvalid && arready;
                r_hs  = rvalid && rready;
                aw_hs = awvalid && awready;
                w_hs  = wvalid && wready;
                b_hs  = bvalid && bready;
                for (int p = 0; p < 2; p++) begin
                    if (rd_addr_ok[p]) begin
                        re.port = p;
                        re.addr = rd_addr[p*32 +: 32];
                        re.size = rd_size[p*2 +: 2];
                        re.data = rd_model(re.addr);
                        rd_q.push_back(re);
                    end
                end
                if (ar_hs) begin
                    s_araddr = araddr; s_arid = arid;
                    n_vec++;
                    if (rd_q.size() == 0) begin
                        n_err++; $display("FAIL ar_unexpected: got addr %h, required no AR", araddr);
                    end else if ({arid, araddr, arsize} !== {4'(rd_q[0].port), rd_q[0].addr, {1'b0, rd_q[0].size}}) begin
                        n_err++;
                        $display("FAIL ar_fields: got id %0d addr %h size %0d, required id %0d addr %h size %0d",
                                 arid, araddr, arsize, rd_q[0].port, rd_q[0].addr, {1'b0, rd_q[0].size});
                    end
                end
                if (rd_data_ok != 2'b00) begin
                    n_vec++; rd_ok_cnt++;
                    if (rd_q.size() == 0 || $countones(rd_data_ok) != 1) begin
                        n_err++; $display("FAIL rd_data_ok_extra: got %b, required none pending", rd_data_ok);
                    end else begin
                        re = rd_q.pop_front();
                        if (rd_data_ok !== (2'b01 << re.port) || rd_rdata !== re.data) begin
                            n_err++;
                            $display("FAIL rd_data: got ok %b data %h, required ok %b data %h",
                                     rd_data_ok, rd_rdata, 2'b01 << re.port, re.data);
                        end else
                            $display("read  port %0d addr %h data %h", re.port, re.addr, rd_rdata);
                    end
                end
                if (wr_addr_ok) begin
                    we.addr = wr_addr; we.size = wr_size; we.strb = wr_wstrb; we.data = wr_wdata;
                    wr_q.push_back(we);
                end
                if (aw_hs) begin s_awaddr = awaddr; s_awid = awid; s_awsize = awsize; aw_got = 1; end
                if (w_hs)  begin s_wdata = wdata; s_wstrb = wstrb; s_wid = wid; s_wlast = wlast; w_got = 1; end
                if (wr_data_ok) begin
                    n_vec++; wr_ok_cyc = cyc;
                    if (wr_q.size() == 0) begin
                        n_err++; $display("FAIL wr_data_ok_extra: got 1, required 0");
                    end else begin
                        we = wr_q.pop_front();
                        if ({s_awaddr, s_awsize, s_wstrb, s_wdata, s_awid, s_wid, s_wlast} !==
                            {we.addr, {1'b0, we.size}, we.strb, we.data, 4'd1, 4'd1, 1'b1}) begin
                            n_err++;
                            $display("FAIL wr_fields: got addr %h size %0d strb %b data %h id %0d/%0d last %b, required addr %h size %0d strb %b data %h id 1/1 last 1",
                                     s_awaddr, s_awsize, s_wstrb, s_wdata, s_awid, s_wid, s_wlast,
                                     we.addr, {1'b0, we.size}, we.strb, we.data);
                        end else
                            $display("write addr %h strb %b data %h", we.addr, we.strb, we.data);
                    end
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (reset) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                {r_pend, b_pend, aw_got, w_got} = '0;
                {ar_cnt, aw_cnt, w_cnt} = '0;
            end else begin
                if (r_hs) begin rvalid = 0; r_pend = 0; end
                if (ar_hs) begin r_pend = 1; r_cnt = r_lat; end
                if (r_pend && !rvalid) begin
                    if (r_cnt == 0) begin rvalid = 1; rdata = rd_model(s_araddr); rid = s_arid; rlast = 1; end
                    else r_cnt--;
                end
                if (arvalid) begin arready = (ar_cnt >= ar_lat); ar_cnt++; end else begin arready = 0; ar_cnt = 0; end
                if (awvalid) begin awready = (aw_cnt >= aw_lat); aw_cnt++; end else begin awready = 0; aw_cnt = 0; end
                if (wvalid)  begin wready  = (w_cnt  >= w_lat);  w_cnt++;  end else begin wready  = 0; w_cnt  = 0; end
                if (b_hs) begin bvalid = 0; b_pend = 0; aw_got = 0; w_got = 0; end
                if (aw_got && w_got && !b_pend) begin b_pend = 1; b_cnt = b_lat; end
                if (b_pend && !bvalid) begin
                    if (b_cnt == 0) begin bvalid = 1; bid = s_awid; end
                    else b_cnt--;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk); #2;
    endtask

    task automatic do_reset;
        rd_req = '0; wr_req = 1'b0; reset = 1'b1;
        tick; tick;
        reset = 1'b0;
        rd_q.delete(); wr_q.delete();
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        bit done = 0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            if (rd_q.size() == 0 && wr_q.size() == 0) done = 1;
            else tick;
        end
        n_vec++;
        if (!done) begin
            n_err++; $display("FAIL %s_timeout: got %0d reads %0d writes pending, required 0", name, rd_q.size(), wr_q.size());
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; rd_req = 2'b11; rd_addr = {32'h40, 32'h80}; wr_req = 1'b1;
        tick; tick; #1;
        n_vec++;
        if ({arvalid, rready, awvalid, wvalid, bready, rd_addr_ok, rd_data_ok, wr_addr_ok, wr_data_ok} !== 11'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b, required 0",
                     {arvalid, rready, awvalid, wvalid, bready, rd_addr_ok, rd_data_ok, wr_addr_ok, wr_data_ok});
        end
        n_vec++;
        if ({arlen, arburst, arlock, arcache, arprot, awlen, awburst, awlock, awcache, awprot} !==
            {8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0}) begin
            n_err++; $display("FAIL axi_constants: got arlen %0d arburst %b awlen %0d awburst %b, required 0/01/0/01",
                              arlen, arburst, awlen, awburst);
        end
        rd_req = '0; wr_req = 1'b0; reset = 1'b0;
        tick;
    endtask

    task automatic test_single_fetch;
        int ok0;
        do_reset;
        ar_lat = 0; r_lat = 3;
        ok0 = rd_ok_cnt;
        rd_addr[31:0] = 32'h1c00_0000; rd_size[1:0] = 2'd2; rd_req = 2'b01;
        #1; n_vec++;
        if (rd_addr_ok !== 2'b01) begin n_err++; $display("FAIL fetch_addr_ok: got %b, required 01", rd_addr_ok); end
        tick; rd_req = '0; #1;
        n_vec++;
        if ({arvalid, araddr, arid, arsize} !== {1'b1, 32'h1c00_0000, 4'd0, 3'd2}) begin
            n_err++; $display("FAIL fetch_ar: got valid %b addr %h id %0d size %0d, required 1 1c000000 0 2",
                              arvalid, araddr, arid, arsize);
        end
        wait_idle("fetch", 30);
        tick; n_vec++;
        if (rd_ok_cnt - ok0 != 1) begin
            n_err++; $display("FAIL fetch_data_ok_cycles: got %0d, required 1", rd_ok_cnt - ok0);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_g;
        bit found;
        do_reset;
        ar_lat = 0; r_lat = 0;
        rd_addr = {32'h0000_2000, 32'h0000_1000}; rd_size = {2'd2, 2'd2}; rd_req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
            found = 0;
            for (int c = 0; c < 20 && !found; c++) begin
                #1;
                if (rd_addr_ok != 2'b00) found = 1; else tick;
            end
            n_vec++;
            if (rd_addr_ok !== exp_g) begin
                n_err++; $display("FAIL rr_grant%0d: got %b, required %b", g, rd_addr_ok, exp_g);
            end
            tick;
        end
        rd_req = '0;
        wait_idle("rr", 30);
    endtask

    task automatic test_store_load;
        int grant_cyc = -1;
        do_reset;
        ar_lat = 0; r_lat = 1; aw_lat = 0; w_lat = 0; b_lat = 6;
        wr_addr = 32'h100; wr_size = 2'd1; wr_wstrb = 4'b0011; wr_wdata = 32'h1234; wr_req = 1'b1;
        #1; n_vec++;
        if (wr_addr_ok !== 1'b1) begin n_err++; $display("FAIL raw_wr_addr_ok: got %b, required 1", wr_addr_ok); end
        tick; wr_req = 1'b0;
        rd_addr = {32'h102, 32'h200}; rd_size = {2'd1, 2'd2}; rd_req = 2'b11;
        #1; n_vec++;
        if (rd_addr_ok !== 2'b01) begin n_err++; $display("FAIL raw_other_grant: got %b, required 01", rd_addr_ok); end
        tick; rd_req = 2'b10;
        for (int c = 0; c < 40 && grant_cyc < 0; c++) begin
            #1;
            if (rd_addr_ok[1]) grant_cyc = cyc; else tick;
        end
        n_vec++;
        if (grant_cyc < 0 || wr_ok_cyc < 0 || grant_cyc != wr_ok_cyc + 1) begin
            n_err++; $display("FAIL raw_block: got grant cycle %0d, required %0d", grant_cyc, wr_ok_cyc + 1);
        end
        tick; rd_req = '0;
        wait_idle("raw", 30);
    endtask

    task automatic test_aw_w_skew;
        int bad = 0;
        do_reset;
        aw_lat = 5; w_lat = 0; b_lat = 0;
        wr_addr = 32'h300; wr_size = 2'd2; wr_wstrb = 4'b1111; wr_wdata = 32'hA5A5_0F0F; wr_req = 1'b1;
        tick; wr_req = 1'b0; #1;
        n_vec++;
        if ({awvalid, wvalid} !== 2'b11) begin n_err++; $display("FAIL skew_start: got %b, required 11", {awvalid, wvalid}); end
        tick; #1;
        n_vec++;
        if ({wvalid, awvalid, bready} !== 3'b010) begin
            n_err++; $display("FAIL skew_wdrop: got wvalid/awvalid/bready %b, required 010", {wvalid, awvalid, bready});
        end
        for (int c = 0; c < 20 && awvalid; c++) begin
            if (awaddr !== 32'h300 || bready || wvalid) bad++;
            tick; #1;
        end
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL skew_hold: got %0d unstable cycles, required 0", bad); end
        n_vec++;
        if ({awvalid, bready} !== 2'b01) begin
            n_err++; $display("FAIL skew_bready: got awvalid/bready %b, required 01", {awvalid, bready});
        end
        wait_idle("skew", 30);
    endtask

    task automatic test_concurrency;
        do_reset;
        ar_lat = 0; r_lat = 2; aw_lat = 0; w_lat = 0; b_lat = 2;
        rd_addr[31:0] = 32'h400; rd_size[1:0] = 2'd0; rd_req = 2'b01;
        wr_addr = 32'h800; wr_size = 2'd2; wr_wstrb = 4'b1000; wr_wdata = 32'hCAFE_0001; wr_req = 1'b1;
        #1; n_vec++;
        if ({rd_addr_ok, wr_addr_ok} !== 3'b011) begin
            n_err++; $display("FAIL conc_accept: got %b, required 011", {rd_addr_ok, wr_addr_ok});
        end
        tick; rd_req = '0; wr_req = 1'b0; #1;
        n_vec++;
        if ({arvalid, awvalid} !== 2'b11) begin
            n_err++; $display("FAIL conc_valid: got ar/aw %b, required 11", {arvalid, awvalid});
        end
        wait_idle("conc", 30);
    endtask

    task automatic test_reset_in_rr;
        bit in_r = 0;
        do_reset;
        ar_lat = 0; r_lat = 10;
        rd_addr[31:0] = 32'h500; rd_size[1:0] = 2'd2; rd_req = 2'b01;
        tick; rd_req = '0;
        for (int c = 0; c < 10 && !in_r; c++) begin
            #1;
            if (rready) in_r = 1; else tick;
        end
        n_vec++;
        if (!in_r) begin n_err++; $display("FAIL rrst_reach_r: got rready 0, required 1"); end
        tick;
        reset = 1'b1;
        tick; reset = 1'b0; #1;
        n_vec++;
        if ({arvalid, rready, rd_data_ok} !== 4'b0) begin
            n_err++; $display("FAIL rrst_outputs: got %b, required 0", {arvalid, rready, rd_data_ok});
        end
        rd_q.delete();
        r_lat = 1;
        rd_addr[63:32] = 32'h600; rd_size[3:2] = 2'd2; rd_req = 2'b10;
        #1; n_vec++;
        if (rd_addr_ok !== 2'b10) begin n_err++; $display("FAIL rrst_fresh: got %b, required 10", rd_addr_ok); end
        tick; rd_req = '0;
        wait_idle("rrst", 30);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; rd_req = '0; rd_addr = '0; rd_size = '0;
        wr_req = 1'b0; wr_addr = '0; wr_size = '0; wr_wstrb = '0; wr_wdata = '0;
        test_reset;
        test_single_fetch;
        test_round_robin;
        test_store_load;
        test_aw_w_skew;
        test_concurrency;
        test_reset_in_rr;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
